// File: rtl/custom_palette_ctrl.sv
// Custom palette controller: loads a 64-entry RGB555 palette from the ioctl
// download stream and shares one RAM port between pixel lookups and loader writes.
module custom_palette_ctrl #(
  parameter logic [7:0] INDEX   = 8'd2,
  parameter int         ENTRIES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce_n,
  input  logic [5:0]  color,
  output logic [14:0] custom_pixel,
  output logic        custom_valid,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        load_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_ENTRY = 6'(ENTRIES - 1);

  state_t      state_r;
  logic        dl_prev_r;
  logic [1:0]  byte_phase_r;
  logic [5:0]  entry_r;
  logic        wr_pending_r;
  logic [14:0] wr_word_r;
  logic [7:0]  red_r;
  logic [7:0]  green_r;
  logic [14:0] pal_mem_r [ENTRIES];

  logic rise_s;
  logic fall_s;
  logic commit_s;

  function automatic logic [14:0] pack_rgb555(input logic [7:0] r,
                                              input logic [7:0] g,
                                              input logic [7:0] b);
    return {b[7:3], g[7:3], r[7:3]};
  endfunction

  assign rise_s     = ioctl_download & ~dl_prev_r;
  assign fall_s     = ~ioctl_download & dl_prev_r;
  // A pending write only gets the port on a clk without a pixel lookup
  assign commit_s   = wr_pending_r & ~pix_ce_n;
  assign ioctl_wait = wr_pending_r;

  // Load sequencing: byte assembly, entry counting and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      dl_prev_r    <= 1'b0;
      byte_phase_r <= 2'd0;
      entry_r      <= 6'd0;
      wr_pending_r <= 1'b0;
      wr_word_r    <= 15'd0;
      red_r        <= 8'd0;
      green_r      <= 8'd0;
      custom_valid <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      dl_prev_r <= ioctl_download;
      case (state_r)
        IDLE: begin
          if (rise_s && (ioctl_index == INDEX)) begin
            state_r      <= LOAD;
            custom_valid <= 1'b0;
            load_err     <= 1'b0;
            byte_phase_r <= 2'd0;
            entry_r      <= 6'd0;
            wr_pending_r <= 1'b0;
          end
        end
        LOAD: begin
          if (commit_s && (entry_r == LAST_ENTRY)) begin
            state_r      <= DONE;
            custom_valid <= 1'b1;
            wr_pending_r <= 1'b0;
          end else if (fall_s) begin
            state_r      <= IDLE;
            load_err     <= 1'b1;
            wr_pending_r <= 1'b0;
          end else begin
            if (commit_s) begin
              wr_pending_r <= 1'b0;
              entry_r      <= entry_r + 6'd1;
            end
            if (ioctl_wr) begin
              // A byte arriving while the previous word still waits is lost
              if (wr_pending_r) begin
                load_err <= 1'b1;
              end else begin
                case (byte_phase_r)
                  2'd0: begin
                    red_r        <= ioctl_dout;
                    byte_phase_r <= 2'd1;
                  end
                  2'd1: begin
                    green_r      <= ioctl_dout;
                    byte_phase_r <= 2'd2;
                  end
                  2'd2: begin
                    wr_word_r    <= pack_rgb555(red_r, green_r, ioctl_dout);
                    wr_pending_r <= 1'b1;
                    byte_phase_r <= 2'd0;
                  end
                  default: begin
                    byte_phase_r <= 2'd0;
                  end
                endcase
              end
            end
          end
        end
        DONE: begin
          if (!ioctl_download) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Loader side of the RAM port; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && commit_s && (state_r == LOAD)) begin
      pal_mem_r[entry_r] <= wr_word_r;
    end
  end

  // Pixel side of the RAM port, result held until the next lookup
  always_ff @(posedge clk) begin
    if (reset) begin
      custom_pixel <= 15'd0;
    end else if (pix_ce_n) begin
      custom_pixel <= pal_mem_r[color];
    end
  end

endmodule
